// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and default sizing for the ID-stage register file.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [2:0]  lc3b_reg;

  localparam int REGFILE_NUM_RD   = 4;
  localparam int REGFILE_MAX_PEND = 3;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/issue/writeback bus into the register file and scoreboard.
interface regfile_scoreboard_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = 4
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0]       rd_busy;
  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [WIDTH-1:0]        wr_data;
  logic                    wr_retire;
  logic                    issue_en;
  logic [AW-1:0]           issue_dest;
  logic                    issue_ok;
  logic                    flush;
  logic                    sb_err;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_retire, issue_en, issue_dest, flush,
    input  rd_data, rd_busy, issue_ok, sb_err
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_retire, issue_en, issue_dest, flush,
    output rd_data, rd_busy, issue_ok, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter. inc is only asserted by the parent
// when the issue was accepted, so the counter can never pass MAX_PEND.
module sb_counter #(
  parameter  int MAX_PEND = 3,
  localparam int CW       = $clog2(MAX_PEND+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          underflow
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dec_eff;

  // Next count: clear wins, then +inc -dec with a retire at zero ignored.
  always_comb begin
    cnt_d   = cnt_q;
    dec_eff = dec && (cnt_q != '0);
    if (clr)
      cnt_d = '0;
    else if (inc && !dec_eff && (cnt_q != CW'(MAX_PEND)))
      cnt_d = cnt_q + CW'(1);
    else if (dec_eff && !inc)
      cnt_d = cnt_q - CW'(1);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt       = cnt_q;
  assign full      = (cnt_q == CW'(MAX_PEND));
  assign underflow = dec && (cnt_q == '0);
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with same-cycle write bypass and a pending-write scoreboard.
module regfile_scoreboard
  import lc3b_types::*;
#(
  parameter int WIDTH    = $bits(lc3b_word),
  parameter int NUM_REGS = 8,
  parameter int NUM_RD   = REGFILE_NUM_RD,
  parameter int MAX_PEND = REGFILE_MAX_PEND
) (
  input logic             clk,
  input logic             reset,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(MAX_PEND+1);

  logic [WIDTH-1:0]    regs_q [NUM_REGS];
  logic [CW-1:0]       cnt    [NUM_REGS];
  logic [NUM_REGS-1:0] retire, inc, full, underflow;
  logic                issue_ok;
  logic                sb_err_q, sb_err_d;

  // Decode retire/issue per register; a full register still accepts an
  // issue when it is retiring in the same cycle.
  always_comb begin
    retire   = '0;
    inc      = '0;
    for (int r = 0; r < NUM_REGS; r++)
      retire[r] = bus.wr_en && bus.wr_retire && (bus.wr_addr == AW'(r));
    issue_ok = !reset && bus.issue_en &&
               (!full[bus.issue_dest] || retire[bus.issue_dest]);
    for (int r = 0; r < NUM_REGS; r++)
      inc[r] = issue_ok && (bus.issue_dest == AW'(r));
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(.MAX_PEND(MAX_PEND)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clr       (bus.flush),
      .inc       (inc[r]),
      .dec       (retire[r]),
      .cnt       (cnt[r]),
      .full      (full[r]),
      .underflow (underflow[r])
    );
  end

  // Data array: plain flops, every register writable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (bus.wr_en) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Sticky error: retire against an empty counter; masked by flush.
  always_comb sb_err_d = sb_err_q | ((|underflow) && !bus.flush);

  // Error flag register.
  always_ff @(posedge clk) begin
    if (reset) sb_err_q <= 1'b0;
    else       sb_err_q <= sb_err_d;
  end

  // Read ports: bypass the in-flight write; busy already accounts for a
  // final retire landing this cycle, but not for a same-cycle issue.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.rd_addr[p*AW +: AW];
    assign bus.rd_data[p*WIDTH +: WIDTH] =
      (bus.wr_en && (bus.wr_addr == a)) ? bus.wr_data : regs_q[a];
    assign bus.rd_busy[p] = (cnt[a] != '0) && !(retire[a] && (cnt[a] == CW'(1)));
  end

  assign bus.issue_ok = issue_ok;
  assign bus.sb_err   = sb_err_q;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (WIDTH=16, 8 regs, 4 read ports, MAX_PEND=3).
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.WIDTH(16), .NUM_REGS(8), .NUM_RD(4)) bus ();

  regfile_scoreboard #(.WIDTH(16), .NUM_REGS(8), .NUM_RD(4), .MAX_PEND(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [2:0] a);
    bus.rd_addr[p*3 +: 3] = a;
  endtask

  task automatic clear_ctl;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_retire = 0;
    bus.issue_en = 0; bus.issue_dest = 0; bus.flush = 0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic ret);
    bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d; bus.wr_retire = ret;
  endtask

  task automatic test_reset;
    reset = 1; clear_ctl(); bus.rd_addr = '0;
    bus.issue_en = 1;
    #1;
    checks++;
    if (bus.issue_ok !== 1'b0) begin
      failures++; $display("FAIL reset_issue_ok got=%b exp=0", bus.issue_ok);
    end
    tick(); tick();
    reset = 0; bus.issue_en = 0;
    for (int p = 0; p < 4; p++) set_rd(p, 3'(p));
    #1;
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (bus.rd_data[p*16 +: 16] !== 16'h0000) begin
        failures++; $display("FAIL reset_data p%0d got=%h exp=0000", p, bus.rd_data[p*16 +: 16]);
      end
      checks++;
      if (bus.rd_busy[p] !== 1'b0) begin
        failures++; $display("FAIL reset_busy p%0d got=%b exp=0", p, bus.rd_busy[p]);
      end
    end
    checks++;
    if (bus.sb_err !== 1'b0) begin
      failures++; $display("FAIL reset_sb_err got=%b exp=0", bus.sb_err);
    end
  endtask

  task automatic test_bypass;
    set_rd(2, 5);
    wr(5, 16'hBEEF, 0);
    #1;
    checks++;
    if (bus.rd_data[32 +: 16] !== 16'hBEEF) begin
      failures++; $display("FAIL bypass_same got=%h exp=BEEF", bus.rd_data[32 +: 16]);
    end
    tick();
    clear_ctl();
    #1;
    checks++;
    if (bus.rd_data[32 +: 16] !== 16'hBEEF) begin
      failures++; $display("FAIL bypass_array got=%h exp=BEEF", bus.rd_data[32 +: 16]);
    end
  endtask

  task automatic test_issue_sat;
    set_rd(0, 3);
    bus.issue_en = 1; bus.issue_dest = 3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.issue_ok !== 1'b1) begin
        failures++; $display("FAIL sat_issue%0d got=%b exp=1", i, bus.issue_ok);
      end
      if (i == 0) begin
        checks++;
        if (bus.rd_busy[0] !== 1'b0) begin
          failures++; $display("FAIL sat_busy_same_cycle got=%b exp=0", bus.rd_busy[0]);
        end
      end
      tick();
    end
    #1;
    checks++;
    if (bus.issue_ok !== 1'b0) begin
      failures++; $display("FAIL sat_issue_full got=%b exp=0", bus.issue_ok);
    end
    tick();
    wr(3, 16'h0303, 1);
    #1;
    checks++;
    if (bus.issue_ok !== 1'b1) begin
      failures++; $display("FAIL sat_issue_retire got=%b exp=1", bus.issue_ok);
    end
    checks++;
    if (bus.rd_busy[0] !== 1'b1) begin
      failures++; $display("FAIL sat_busy_retire got=%b exp=1", bus.rd_busy[0]);
    end
    tick();
    bus.wr_en = 0; bus.wr_retire = 0;
    #1;
    checks++;
    if (bus.issue_ok !== 1'b0) begin
      failures++; $display("FAIL sat_still_full got=%b exp=0", bus.issue_ok);
    end
    tick();
    bus.issue_en = 0;
    for (int i = 0; i < 3; i++) begin
      wr(3, 16'h0303, 1);
      #1;
      checks++;
      if (bus.rd_busy[0] !== (i < 2)) begin
        failures++; $display("FAIL sat_drain%0d got=%b exp=%b", i, bus.rd_busy[0], (i < 2));
      end
      tick();
    end
    clear_ctl();
    #1;
    checks++;
    if (bus.rd_busy[0] !== 1'b0 || bus.sb_err !== 1'b0) begin
      failures++; $display("FAIL sat_empty busy=%b err=%b exp=0/0", bus.rd_busy[0], bus.sb_err);
    end
  endtask

  task automatic test_wb_retire;
    set_rd(1, 2);
    bus.issue_en = 1; bus.issue_dest = 2;
    tick();
    bus.issue_en = 0;
    #1;
    checks++;
    if (bus.rd_busy[1] !== 1'b1) begin
      failures++; $display("FAIL wb_busy_pending got=%b exp=1", bus.rd_busy[1]);
    end
    wr(2, 16'h0042, 1);
    #1;
    checks++;
    if (bus.rd_busy[1] !== 1'b0 || bus.rd_data[16 +: 16] !== 16'h0042) begin
      failures++; $display("FAIL wb_same_cycle busy=%b data=%h exp=0/0042", bus.rd_busy[1], bus.rd_data[16 +: 16]);
    end
    tick();
    clear_ctl();
    #1;
    checks++;
    if (bus.rd_busy[1] !== 1'b0 || bus.rd_data[16 +: 16] !== 16'h0042) begin
      failures++; $display("FAIL wb_next busy=%b data=%h exp=0/0042", bus.rd_busy[1], bus.rd_data[16 +: 16]);
    end
  endtask

  task automatic test_flush;
    set_rd(0, 1); set_rd(1, 4);
    bus.issue_en = 1; bus.issue_dest = 1; tick();
    bus.issue_dest = 4; tick();
    bus.issue_en = 0;
    #1;
    checks++;
    if (bus.rd_busy[1:0] !== 2'b11) begin
      failures++; $display("FAIL flush_pre busy=%b exp=11", bus.rd_busy[1:0]);
    end
    bus.flush = 1; wr(1, 16'h1111, 1);
    bus.issue_en = 1; bus.issue_dest = 4;
    tick();
    clear_ctl();
    #1;
    checks++;
    if (bus.rd_busy[1:0] !== 2'b00) begin
      failures++; $display("FAIL flush_busy got=%b exp=00", bus.rd_busy[1:0]);
    end
    checks++;
    if (bus.rd_data[0 +: 16] !== 16'h1111) begin
      failures++; $display("FAIL flush_data got=%h exp=1111", bus.rd_data[0 +: 16]);
    end
    checks++;
    if (bus.sb_err !== 1'b0) begin
      failures++; $display("FAIL flush_sb_err got=%b exp=0", bus.sb_err);
    end
  endtask

  task automatic test_underflow;
    set_rd(2, 6);
    wr(6, 16'h6666, 1);
    #1;
    checks++;
    if (bus.rd_busy[2] !== 1'b0 || bus.rd_data[32 +: 16] !== 16'h6666 || bus.sb_err !== 1'b0) begin
      failures++; $display("FAIL uf_same busy=%b data=%h err=%b exp=0/6666/0", bus.rd_busy[2], bus.rd_data[32 +: 16], bus.sb_err);
    end
    tick();
    clear_ctl();
    #1;
    checks++;
    if (bus.sb_err !== 1'b1) begin
      failures++; $display("FAIL uf_set got=%b exp=1", bus.sb_err);
    end
    tick(); tick();
    checks++;
    if (bus.sb_err !== 1'b1) begin
      failures++; $display("FAIL uf_sticky got=%b exp=1", bus.sb_err);
    end
    bus.issue_en = 1; bus.issue_dest = 0; tick();
    bus.issue_dest = 7; tick();
    bus.issue_en = 0;
    set_rd(0, 0); set_rd(1, 7); set_rd(3, 5);
    #1;
    checks++;
    if (bus.rd_busy[1:0] !== 2'b11) begin
      failures++; $display("FAIL uf_pending busy=%b exp=11", bus.rd_busy[1:0]);
    end
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++;
    if (bus.rd_busy !== 4'b0000 || bus.sb_err !== 1'b0) begin
      failures++; $display("FAIL midreset_state busy=%b err=%b exp=0000/0", bus.rd_busy, bus.sb_err);
    end
    checks++;
    if (bus.rd_data[48 +: 16] !== 16'h0000 || bus.rd_data[32 +: 16] !== 16'h0000) begin
      failures++; $display("FAIL midreset_data r5=%h r6=%h exp=0000/0000", bus.rd_data[48 +: 16], bus.rd_data[32 +: 16]);
    end
  endtask

  task automatic test_back_to_back;
    set_rd(0, 0);
    wr(0, 16'hA5A5, 0);
    tick();
    wr(0, 16'h5A5A, 0);
    #1;
    checks++;
    if (bus.rd_data[0 +: 16] !== 16'h5A5A) begin
      failures++; $display("FAIL b2b_bypass got=%h exp=5A5A", bus.rd_data[0 +: 16]);
    end
    bus.wr_en = 0;
    #1;
    checks++;
    if (bus.rd_data[0 +: 16] !== 16'hA5A5) begin
      failures++; $display("FAIL b2b_first got=%h exp=A5A5", bus.rd_data[0 +: 16]);
    end
    bus.wr_en = 1;
    tick();
    clear_ctl();
    #1;
    checks++;
    if (bus.rd_data[0 +: 16] !== 16'h5A5A) begin
      failures++; $display("FAIL b2b_second got=%h exp=5A5A", bus.rd_data[0 +: 16]);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_issue_sat();
    test_wb_retire();
    test_flush();
    test_underflow();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
